// File: rtl/dmi_arbiter.sv
// DMI request/response types and a round-robin arbiter that shares the debug
// module's single DMI port among NumReq masters. One transaction is owned at a
// time: accept -> issue toward the DM -> wait for the matching response.

package dm;
   typedef struct packed {
      logic [6:0]  addr;
      logic [1:0]  op;
      logic [31:0] data;
   } dmi_req_t;

   typedef struct packed {
      logic [31:0] data;
      logic [1:0]  resp;
   } dmi_resp_t;
endpackage

module dmi_arbiter #(
   parameter int unsigned NumReq = 2,
   parameter int unsigned IdxW   = (NumReq > 1) ? $clog2(NumReq) : 1
) (
   input  logic                          clk_i,
   input  logic                          rst_ni,
   input  dm::dmi_req_t  [NumReq-1:0]    req_i,
   input  logic          [NumReq-1:0]    req_valid_i,
   output logic          [NumReq-1:0]    req_ready_o,
   output dm::dmi_resp_t [NumReq-1:0]    resp_o,
   output logic          [NumReq-1:0]    resp_valid_o,
   input  logic          [NumReq-1:0]    resp_ready_i,
   output dm::dmi_req_t                  dmi_req_o,
   output logic                          dmi_req_valid_o,
   input  logic                          dmi_req_ready_i,
   input  dm::dmi_resp_t                 dmi_resp_i,
   input  logic                          dmi_resp_valid_i,
   output logic                          dmi_resp_ready_o,
   output logic                          busy_o,
   output logic          [IdxW-1:0]      owner_o
);

   if (NumReq < 2 || NumReq > 8) begin : g_bad_numreq
      $error("dmi_arbiter: NumReq must be in 2..8");
   end

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      ISSUE     = 2'd1,
      WAIT_RESP = 2'd2
   } state_e;

   state_e          state_q, state_d;
   dm::dmi_req_t    req_q;
   logic [IdxW-1:0] owner_q;
   logic [IdxW-1:0] rr_q;

   logic            found;
   logic [IdxW-1:0] winner;
   logic [IdxW-1:0] rr_next;
   logic            accept;

   // Round-robin search: first valid requester starting at rr_q, wrapping.
   always_comb begin
      int unsigned j;
      j      = 0;
      found  = 1'b0;
      winner = '0;
      for (int unsigned k = 0; k < NumReq; k++) begin
         j = (32'(rr_q) + k) % NumReq;
         if (!found && req_valid_i[IdxW'(j)]) begin
            found  = 1'b1;
            winner = IdxW'(j);
         end
      end
      rr_next = IdxW'((32'(winner) + 1) % NumReq);
   end

   // State register.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) state_q <= IDLE;
      else         state_q <= state_d;
   end

   // Next state and handshake outputs; response valid is steered to the owner only.
   always_comb begin
      state_d          = state_q;
      accept           = 1'b0;
      req_ready_o      = '0;
      dmi_req_valid_o  = 1'b0;
      dmi_resp_ready_o = 1'b0;
      resp_valid_o     = '0;
      case (state_q)
         IDLE: begin
            if (found) begin
               req_ready_o[winner] = 1'b1;
               accept              = 1'b1;
               state_d             = ISSUE;
            end
         end
         ISSUE: begin
            dmi_req_valid_o = 1'b1;
            if (dmi_req_ready_i) state_d = WAIT_RESP;
         end
         WAIT_RESP: begin
            dmi_resp_ready_o      = resp_ready_i[owner_q];
            resp_valid_o[owner_q] = dmi_resp_valid_i;
            if (dmi_resp_valid_i && resp_ready_i[owner_q]) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Capture the winning request, its owner, and advance the priority pointer.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         req_q   <= '0;
         owner_q <= '0;
         rr_q    <= '0;
      end else if (accept) begin
         req_q   <= req_i[winner];
         owner_q <= winner;
         rr_q    <= rr_next;
      end
   end

   // Response data fans out to every requester; only valid is steered.
   for (genvar g = 0; g < NumReq; g++) begin : g_resp
      assign resp_o[g] = dmi_resp_i;
   end

   assign dmi_req_o = req_q;
   assign busy_o    = (state_q != IDLE);
   assign owner_o   = owner_q;

endmodule

// File: tb/tb_dmi_arbiter.sv
// Randomized bench for dmi_arbiter with four requesters. A transaction-level
// reference model (owned/issued flags, owner, priority pointer, held request)
// predicts every output each cycle.

module tb_dmi_arbiter;
   localparam int N  = 4;
   localparam int IW = 2;
   localparam int RW = $bits(dm::dmi_req_t);
   localparam int PW = $bits(dm::dmi_resp_t);

   logic                clk;
   logic                rst_n;
   dm::dmi_req_t  [N-1:0] req;
   logic          [N-1:0] req_valid;
   logic          [N-1:0] req_ready;
   dm::dmi_resp_t [N-1:0] resp;
   logic          [N-1:0] resp_valid;
   logic          [N-1:0] resp_ready;
   dm::dmi_req_t        dmi_req;
   logic                dmi_req_valid;
   logic                dmi_req_ready;
   dm::dmi_resp_t       dmi_resp;
   logic                dmi_resp_valid;
   logic                dmi_resp_ready;
   logic                busy;
   logic [IW-1:0]       owner;

   int n_chk;
   int n_fail;

   dmi_arbiter #(.NumReq(N)) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .req_i(req), .req_valid_i(req_valid), .req_ready_o(req_ready),
      .resp_o(resp), .resp_valid_o(resp_valid), .resp_ready_i(resp_ready),
      .dmi_req_o(dmi_req), .dmi_req_valid_o(dmi_req_valid), .dmi_req_ready_i(dmi_req_ready),
      .dmi_resp_i(dmi_resp), .dmi_resp_valid_i(dmi_resp_valid), .dmi_resp_ready_o(dmi_resp_ready),
      .busy_o(busy), .owner_o(owner)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model state
   bit           m_owned;
   bit           m_issued;
   int           m_own;
   int           m_ptr;
   dm::dmi_req_t m_req;
   int           grants[$];

   task automatic model_reset();
      m_owned = 0; m_issued = 0; m_own = 0; m_ptr = 0; m_req = '0;
   endtask

   // Compare all outputs against the model, then advance model and clock.
   task automatic step();
      int           win;
      logic [N-1:0] e_rdy, e_rv;
      #1;
      win = -1;
      if (!m_owned)
         for (int k = 0; k < N; k++)
            if (win < 0 && req_valid[(m_ptr + k) % N]) win = (m_ptr + k) % N;
      e_rdy = '0;
      if (win >= 0) e_rdy[win] = 1'b1;
      e_rv = '0;
      if (m_owned && m_issued && dmi_resp_valid) e_rv[m_own] = 1'b1;
      chk("req_ready", 64'(req_ready), 64'(e_rdy));
      chk("dmi_req_valid", 64'(dmi_req_valid), 64'(m_owned && !m_issued));
      chk("dmi_req", 64'(dmi_req), 64'(m_req));
      chk("dmi_resp_ready", 64'(dmi_resp_ready), 64'(m_owned && m_issued && resp_ready[m_own]));
      chk("resp_valid", 64'(resp_valid), 64'(e_rv));
      chk("busy", 64'(busy), 64'(m_owned));
      chk("owner", 64'(owner), 64'(m_own));
      for (int i = 0; i < N; i++) chk("resp_data", 64'(resp[i]), 64'(dmi_resp));
      if (!rst_n) model_reset();
      else if (win >= 0) begin
         m_owned = 1; m_issued = 0; m_own = win; m_ptr = (win + 1) % N; m_req = req[win];
         grants.push_back(win);
      end else if (m_owned && !m_issued && dmi_req_ready) m_issued = 1;
      else if (m_owned && m_issued && dmi_resp_valid && resp_ready[m_own]) m_owned = 0;
      @(posedge clk);
      #1;
   endtask

   task automatic quiet();
      req_valid = '0; dmi_req_ready = 1'b0; dmi_resp_valid = 1'b0; resp_ready = '0;
   endtask

   // One minimal 3-cycle transaction from requester r.
   task automatic txn(input int r);
      logic [RW-1:0] t;
      t = RW'({$urandom, $urandom});
      req[r] = dm::dmi_req_t'(t);
      req_valid = '0; req_valid[r] = 1'b1;
      resp_ready = '1; dmi_req_ready = 1'b1; dmi_resp_valid = 1'b0;
      step();
      req_valid = '0;
      step();
      dmi_resp_valid = 1'b1;
      dmi_resp = dm::dmi_resp_t'(PW'({$urandom, $urandom}));
      step();
      dmi_resp_valid = 1'b0;
   endtask

   initial begin
      logic [RW-1:0] t;
      n_chk = 0; n_fail = 0;
      model_reset();
      req = '0; dmi_resp = '0; quiet();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_owner", 64'(owner), 64'd0);
      chk("rst_dmi_req_valid", 64'(dmi_req_valid), 64'd0);
      chk("rst_dmi_req", 64'(dmi_req), 64'd0);
      chk("rst_resp_valid", 64'(resp_valid), 64'd0);
      chk("rst_dmi_resp_ready", 64'(dmi_resp_ready), 64'd0);
      chk("rst_req_ready", 64'(req_ready), 64'd0);
      rst_n = 1'b1;

      // Write from requester 0, then stall DM ready while requester 1 waits.
      req[0] = '{addr: 7'h10, op: 2'd2, data: 32'hDEADBEEF};
      req_valid = 4'b0001; dmi_req_ready = 1'b1; resp_ready = '1;
      step();
      req_valid = 4'b0000;
      chk("wr_dmi_req", 64'(dmi_req), 64'({7'h10, 2'd2, 32'hDEADBEEF}));
      step();
      dmi_resp = '{data: 32'h0, resp: 2'd0}; dmi_resp_valid = 1'b1;
      step();
      dmi_resp_valid = 1'b0;
      chk("wr_back_idle", 64'(busy), 64'd0);

      req_valid = 4'b0100; dmi_req_ready = 1'b0;
      step();
      req_valid = 4'b0010;
      repeat (5) step();
      chk("stall_no_grant", 64'(req_ready), 64'd0);
      dmi_req_ready = 1'b1;
      step();
      dmi_resp_valid = 1'b1; resp_ready = '1;
      step();
      dmi_resp_valid = 1'b0;
      // rr now 3: requesters 1 and 3 valid -> 3 wins, then 1
      req_valid = 4'b1010;
      step();
      chk("rr_first", 64'(owner), 64'd3);
      quiet(); dmi_req_ready = 1'b1; resp_ready = '1; dmi_resp_valid = 1'b1;
      step(); step();
      req_valid = 4'b1010; dmi_resp_valid = 1'b0;
      step();
      chk("rr_second", 64'(owner), 64'd1);

      // Requester 1 read, resp_ready held low for 3 cycles, spurious requester 0 state
      quiet(); dmi_req_ready = 1'b1;
      step();
      dmi_resp = '{data: 32'h12345678, resp: 2'd0}; dmi_resp_valid = 1'b1; resp_ready = 4'b1101;
      repeat (3) step();
      resp_ready = '1;
      step();
      dmi_resp_valid = 1'b0;

      // Reset while waiting for the response; late response must be ignored.
      txn(2);
      req_valid = 4'b0001; dmi_req_ready = 1'b1;
      step(); req_valid = '0; step();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1; dmi_resp_valid = 1'b1; resp_ready = '1;
      step();
      dmi_resp_valid = 1'b0;

      // Continuous contention from all requesters: strict rotation.
      grants.delete();
      for (int k = 0; k < 8; k++) begin
         req_valid = '1; dmi_req_ready = 1'b1; resp_ready = '1; dmi_resp_valid = 1'b0;
         step();
         step();
         dmi_resp_valid = 1'b1;
         step();
      end
      for (int k = 0; k < 8; k++) chk("rotation", 64'(grants[k]), 64'(k % N));

      // Random traffic.
      for (int c = 0; c < 4000; c++) begin
         rst_n = ($urandom_range(0, 199) != 0);
         for (int i = 0; i < N; i++) begin
            t = RW'({$urandom, $urandom});
            req[i] = dm::dmi_req_t'(t);
         end
         req_valid      = N'($urandom) & N'($urandom);
         resp_ready     = N'($urandom);
         dmi_req_ready  = ($urandom_range(0, 2) != 0);
         dmi_resp_valid = ($urandom_range(0, 2) == 0);
         dmi_resp       = dm::dmi_resp_t'(PW'({$urandom, $urandom}));
         step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/dmi_arbiter.md
# dmi_arbiter

Round-robin arbiter sharing the debug module's single DMI request/response port among `NumReq` DMI masters, e.g. the JTAG DTM CDC output and an on-chip debug bridge. It sits in the DMI clock domain, between the requesters and the debug module. It accepts one request at a time and registers it toward the debug module. It locks onto that requester until the matching response is handed back, then moves the priority pointer.

## Interface
- `NumReq`, default 2: number of requesters; legal values 2..8; elaboration error otherwise.
- `IdxW`, default `$clog2(NumReq)`: width of the owner index; derived, do not override.
- `clk_i`  in  1  DMI clock; single clock for the whole block.
- `rst_ni`  in  1  reset, synchronous and active-low.
- `req_i`  in  `NumReq` x `dm::dmi_req_t`  per-requester request (addr, op, data).
- `req_valid_i`  in  `NumReq`  per-requester request valid.
- `req_ready_o`  out  `NumReq`  per-requester request ready.
- `resp_o`  out  `NumReq` x `dm::dmi_resp_t`  per-requester response (data, resp).
- `resp_valid_o`  out  `NumReq`  per-requester response valid.
- `resp_ready_i`  in  `NumReq`  per-requester response ready.
- `dmi_req_o`  out  `dm::dmi_req_t`  registered request to the debug module.
- `dmi_req_valid_o`  out  1  request valid to the debug module.
- `dmi_req_ready_i`  in  1  debug module request ready.
- `dmi_resp_i`  in  `dm::dmi_resp_t`  debug module response.
- `dmi_resp_valid_i`  in  1  debug module response valid.
- `dmi_resp_ready_o`  out  1  response ready to the debug module.
- `busy_o`  out  1  high while a transaction is owned (state not Idle).
- `owner_o`  out  `IdxW`  index of the current or most recent owner.

## Operation
- FSM states: Idle, Issue, WaitResp. Registers: state, `req_q` (`dmi_req_t`), `owner_q`, `rr_q` (priority pointer).
- Idle:
  - The winner is the first index with `req_valid_i` set, scanning `rr_q`, `rr_q+1`, … modulo `NumReq`.
  - Only the winner sees `req_ready_o` high, combinationally and in the same cycle. All other `req_ready_o` are 0.
  - On the winner's handshake: `req_q` <= `req_i[winner]`, `owner_q` <= winner, `rr_q` <= (winner+1) mod `NumReq`, go to Issue.
  - With no valid requester, stay in Idle; `rr_q` is unchanged.
- Issue: `dmi_req_valid_o`=1 and `dmi_req_o`=`req_q`, both held stable until `dmi_req_ready_i`, then go to WaitResp. All `req_ready_o`=0.
- WaitResp:
  - Response is passed through combinationally: `resp_o[owner_q]`=`dmi_resp_i`, `resp_valid_o[owner_q]`=`dmi_resp_valid_i`, `dmi_resp_ready_o`=`resp_ready_i[owner_q]`.
  - On the handshake (`dmi_resp_valid_i` && `resp_ready_i[owner_q]`), go to Idle.
- Outside WaitResp, `dmi_resp_ready_o`=0 and all `resp_valid_o`=0.
- `resp_o` is driven with `dmi_resp_i` for every index at all times; only the valid bit is steered.
- The arbiter does not interpret `op`. NOP requests are arbitrated and forwarded like any other; the debug module answers them.
- A spurious `dmi_resp_valid_i` outside WaitResp is ignored and not acknowledged.
- Requesters may drop `req_valid_i` without a handshake. The arbitration decision is recomputed every cycle in Idle.
- Reset (`!rst_ni` at the clock edge), including mid-transaction:
  - state=Idle, `req_q`='0, `owner_q`=0, `rr_q`=0.
  - Any in-flight transaction is abandoned. The system resets the debug module and requesters in the same domain together.
- Reset values of outputs:
  - `dmi_req_valid_o`=0, `dmi_req_o`='0, `dmi_resp_ready_o`=0, `busy_o`=0, `owner_o`=0.
  - All `resp_valid_o`=0.
  - `req_ready_o` follows Idle arbitration, so it is nonzero only when a `req_valid_i` is high.

## Timing
- Request acceptance: 0 cycles, same cycle as `req_valid_i` in Idle.
- `dmi_req_valid_o` rises in the cycle after acceptance; minimum 1-cycle request latency.
- Response path: combinational, 0 cycles.
- Minimum transaction length is 3 cycles: accept, issue with ready=1, response with valid and ready=1. The next acceptance is possible in the following cycle.
- No combinational path from `dmi_req_ready_i` to any `req_ready_o`.
- `dmi_req_o` is driven only from flops.

## Test plan
- Single requester 0 writes addr 0x10, data 0xDEADBEEF, op WRITE; DM ready=1, responds SUCCESS one cycle later -> `dmi_req_o` matches in the cycle after acceptance; `resp_valid_o`=2'b01; back to Idle after 3 cycles.
- Both requesters valid continuously from reset -> grants in order 0,1,0,1; `owner_o` toggles; neither requester waits more than one transaction.
- DM holds `dmi_req_ready_i`=0 for 5 cycles -> `dmi_req_valid_o` and `dmi_req_o` stay stable; requester 1 valid meanwhile is not accepted (`req_ready_o[1]`=0).
- Requester 1 owns a read and the DM returns data 0x12345678 while `resp_ready_i[1]`=0 for 3 cycles -> `dmi_resp_ready_o`=0 for those 3 cycles; handshake on cycle 4; `resp_valid_o[0]` never asserts.
- `rst_ni`=0 for one cycle while in WaitResp -> next cycle all outputs at reset values, `rr_q`=0; a late `dmi_resp_valid_i` is not acknowledged.
- `NumReq`=4, requesters 1 and 3 valid, `rr_q`=2 -> requester 3 is granted first, then requester 1.
